// File: rtl/aes_bist_ctrl.sv
// Purpose: built-in self-test sequencer that runs the AES-256 known-answer vector through the core (encrypt, then decrypt).
// Latency: start sampled at cycle 0; with an always-ready core that answers 1 cycle after accept, done_o rises at cycle 5.
// Backpressure: requests are held indefinitely while core_ready_i is low; responses are consumed only in a WAIT state, each bounded by TIMEOUT_CYCLES.
module aes_bist_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic         enc_pass_o,
  output logic         dec_pass_o,
  output logic         timeout_o,
  output logic         core_v_o,
  input  logic         core_ready_i,
  output logic         core_decrypt_o,
  output logic [127:0] core_data_o,
  output logic [255:0] core_key_o,
  input  logic         core_v_i,
  input  logic [127:0] core_data_i,
  output logic         core_yumi_o
);

  // Known-answer vector for AES-256.
  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENC_REQ  = 3'd1;
  localparam logic [2:0] S_ENC_WAIT = 3'd2;
  localparam logic [2:0] S_DEC_REQ  = 3'd3;
  localparam logic [2:0] S_DEC_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // The counter starts at 0 in the first WAIT cycle. The timeout fires on the
  // cycle whose increment would make it reach TIMEOUT_CYCLES-1, provided no
  // response arrives in that same cycle.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 enc_pass_q, enc_pass_d;
  logic                 dec_pass_q, dec_pass_d;
  logic                 timeout_q, timeout_d;

  logic in_wait;
  logic in_req;

  assign in_wait = (state_q == S_ENC_WAIT) || (state_q == S_DEC_WAIT);
  assign in_req  = (state_q == S_ENC_REQ)  || (state_q == S_DEC_REQ);

  // Next-state, timeout counter and result flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enc_pass_d = enc_pass_q;
    dec_pass_d = dec_pass_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_ENC_REQ;
          cnt_d      = '0;
          enc_pass_d = 1'b0;
          dec_pass_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      S_ENC_REQ: begin
        if (core_ready_i) begin
          state_d = S_ENC_WAIT;
          cnt_d   = '0;
        end
      end
      S_ENC_WAIT: begin
        // A response in the timeout cycle takes priority over the timeout.
        if (core_v_i) begin
          enc_pass_d = (core_data_i == KAT_CT);
          cnt_d      = '0;
          state_d    = S_DEC_REQ;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DEC_REQ: begin
        if (core_ready_i) begin
          state_d = S_DEC_WAIT;
          cnt_d   = '0;
        end
      end
      S_DEC_WAIT: begin
        if (core_v_i) begin
          dec_pass_d = (core_data_i == KAT_PT);
          cnt_d      = '0;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and result registers; reset aborts any run at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      enc_pass_q <= 1'b0;
      dec_pass_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enc_pass_q <= enc_pass_d;
      dec_pass_q <= dec_pass_d;
      timeout_q  <= timeout_d;
    end
  end

  // Request fields decode from state only, so they stay stable under backpressure.
  // Decryption always uses the constant ciphertext so both checks are independent.
  assign core_v_o       = in_req;
  assign core_decrypt_o = (state_q == S_DEC_REQ);
  assign core_data_o    = (state_q == S_ENC_REQ) ? KAT_PT :
                          (state_q == S_DEC_REQ) ? KAT_CT : 128'h0;
  assign core_key_o     = in_req ? KAT_KEY : 256'h0;
  assign core_yumi_o    = in_wait & core_v_i;

  assign busy_o     = in_req | in_wait;
  assign done_o     = (state_q == S_DONE);
  assign enc_pass_o = enc_pass_q;
  assign dec_pass_o = dec_pass_q;
  assign timeout_o  = timeout_q;
  assign pass_o     = enc_pass_q & dec_pass_q & ~timeout_q;

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Purpose: self-checking bench for aes_bist_ctrl driving a behavioural AES core lookup model.
// Latency: checks done timing against a cycle count computed from per-operation ready/response delays.
// Backpressure: randomizes ready stalls, response latency, corrupted results and dropped responses.
module tb_aes_bist_ctrl;

  localparam int T = 16;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         start_i;
  logic         busy_o, done_o, pass_o, enc_pass_o, dec_pass_o, timeout_o;
  logic         core_v_o, core_ready_i, core_decrypt_o;
  logic [127:0] core_data_o;
  logic [255:0] core_key_o;
  logic         core_v_i;
  logic [127:0] core_data_i;
  logic         core_yumi_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  aes_bist_ctrl #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(5)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .enc_pass_o     (enc_pass_o),
    .dec_pass_o     (dec_pass_o),
    .timeout_o      (timeout_o),
    .core_v_o       (core_v_o),
    .core_ready_i   (core_ready_i),
    .core_decrypt_o (core_decrypt_o),
    .core_data_o    (core_data_o),
    .core_key_o     (core_key_o),
    .core_v_i       (core_v_i),
    .core_data_i    (core_data_i),
    .core_yumi_o    (core_yumi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
    cyc++;
  endtask

  // Reference core: only the known-answer pairs produce the right answer.
  function automatic logic [127:0] core_model(input logic dec, input logic [127:0] d, input logic [255:0] k);
    if (k == KEY && !dec && d == PT) return CT;
    if (k == KEY && dec && d == CT) return PT;
    return ~d;
  endfunction

  // Serve one request; entered with the DUT in a REQ state.
  task automatic do_op(input bit dec, input int rdy, input int lat, input bit bad, input bit drop);
    logic [127:0] exp_req, resp;
    logic         req_dec;
    logic [127:0] req_data;
    logic [255:0] req_key;
    int n;
    exp_req = dec ? CT : PT;
    chk("req_v", core_v_o, 1);
    chk("req_dec", core_decrypt_o, dec);
    chk("req_data", core_data_o, exp_req);
    chk("req_key", core_key_o, KEY);
    chk("req_busy", busy_o, 1);
    for (int i = 0; i < rdy; i++) begin
      core_ready_i = 1'b0;
      core_v_i     = 1'($urandom_range(0, 1));
      core_data_i  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("yumi_in_req", core_yumi_o, 0);
      step();
      core_v_i = 1'b0;
      chk("hold_v", core_v_o, 1);
      chk("hold_data", core_data_o, exp_req);
      chk("hold_key", core_key_o, KEY);
      chk("hold_dec", core_decrypt_o, dec);
      chk("hold_timeout", timeout_o, 0);
    end
    req_dec  = core_decrypt_o;
    req_data = core_data_o;
    req_key  = core_key_o;
    core_ready_i = 1'b1;
    step();
    core_ready_i = 1'b0;
    chk("wait_v", core_v_o, 0);
    if (drop) begin
      n = 0;
      while (!done_o && n < 100) begin
        step();
        n++;
      end
      chk("timeout_latency", n, T - 1);
      chk("timeout_flag", timeout_o, 1);
    end else begin
      repeat (lat) step();
      resp = core_model(req_dec, req_data, req_key);
      if (bad) resp = resp ^ {96'h0, $urandom | 32'h1};
      core_v_i    = 1'b1;
      core_data_i = resp;
      #1;
      chk("yumi", core_yumi_o, 1);
      step();
      core_v_i = 1'b0;
    end
  endtask

  // One full run, checked against expected flags and done cycle.
  task automatic run(input int r1, input int l1, input bit b1, input bit d1,
                     input int r2, input int l2, input bit b2, input bit d2);
    int t0, exp_done;
    bit e_enc, e_dec, e_to;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    t0 = cyc;
    chk("start_done_clr", done_o, 0);
    chk("start_enc_clr", enc_pass_o, 0);
    chk("start_dec_clr", dec_pass_o, 0);
    chk("start_to_clr", timeout_o, 0);
    do_op(1'b0, r1, l1, b1, d1);
    if (!d1) do_op(1'b1, r2, l2, b2, d2);
    e_enc = !d1 && !b1;
    e_dec = !d1 && !d2 && !b2;
    e_to  = d1 || d2;
    exp_done = t0 + r1 + 1 + (d1 ? T - 1 : (l1 + 1 + r2 + 1 + (d2 ? T - 1 : l2 + 1)));
    chk("done_cycle", cyc, exp_done);
    chk("done", done_o, 1);
    chk("done_busy", busy_o, 0);
    chk("enc_pass", enc_pass_o, e_enc);
    chk("dec_pass", dec_pass_o, e_dec);
    chk("timeout", timeout_o, e_to);
    chk("pass", pass_o, e_enc && e_dec && !e_to);
    chk("done_v", core_v_o, 0);
    core_v_i = 1'b1;
    #1;
    chk("yumi_in_done", core_yumi_o, 0);
    core_v_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, l1, r2, l2;
    bit b1, d1, b2, d2;
    reset_i      = 1'b1;
    start_i      = 1'b0;
    core_ready_i = 1'b0;
    core_v_i     = 1'b0;
    core_data_i  = '0;
    #1;
    step();
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_enc", enc_pass_o, 0);
    chk("rst_dec", dec_pass_o, 0);
    chk("rst_to", timeout_o, 0);
    chk("rst_v", core_v_o, 0);
    chk("rst_decrypt", core_decrypt_o, 0);
    chk("rst_data", core_data_o, 0);
    chk("rst_key", core_key_o, 0);
    core_v_i = 1'b1;
    #1;
    chk("rst_yumi", core_yumi_o, 0);
    core_v_i = 1'b0;
    reset_i = 1'b0;
    step();
    chk("idle_busy", busy_o, 0);

    // Ideal core, zero wait: done at cycle 5.
    run(0, 0, 0, 0, 0, 0, 0, 0);
    // Wrong encrypt result.
    run(0, 0, 1, 0, 0, 0, 0, 0);
    // Decrypt never answered.
    run(0, 0, 0, 0, 0, 0, 0, 1);
    // Encrypt never answered.
    run(2, 0, 0, 1, 0, 0, 0, 0);
    // Long ready stall, no timeout.
    run(50, 0, 0, 0, 0, 0, 0, 0);
    // Responses in the last allowed cycle win over the timeout.
    run(0, T - 2, 0, 0, 1, T - 2, 0, 0);

    // Reset mid ENC_WAIT aborts asynchronously.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    core_ready_i = 1'b1;
    step();
    core_ready_i = 1'b0;
    chk("pre_rst_busy", busy_o, 1);
    reset_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_v", core_v_o, 0);
    chk("arst_data", core_data_o, 0);
    chk("arst_key", core_key_o, 0);
    chk("arst_done", done_o, 0);
    step();
    reset_i = 1'b0;
    step();
    chk("post_rst_v", core_v_o, 0);
    run(0, 1, 0, 0, 0, 1, 0, 0);

    // start_i held high: one run, then relaunch from DONE clears results.
    start_i = 1'b1;
    step();
    do_op(1'b0, 0, 0, 0, 0);
    do_op(1'b1, 1, 2, 0, 0);
    chk("held_done", done_o, 1);
    chk("held_pass", pass_o, 1);
    step();
    chk("relaunch_done", done_o, 0);
    chk("relaunch_enc_clr", enc_pass_o, 0);
    chk("relaunch_dec_clr", dec_pass_o, 0);
    chk("relaunch_busy", busy_o, 1);
    start_i = 1'b0;
    do_op(1'b0, 0, 0, 0, 0);
    do_op(1'b1, 0, 0, 0, 0);
    chk("relaunch_pass", pass_o, 1);

    // Randomized runs.
    for (int it = 0; it < 25; it++) begin
      r1 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      r2 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      l1 = $urandom_range(0, T - 2);
      l2 = $urandom_range(0, T - 2);
      b1 = ($urandom_range(0, 3) == 0);
      b2 = ($urandom_range(0, 3) == 0);
      d1 = ($urandom_range(0, 5) == 0);
      d2 = ($urandom_range(0, 5) == 0);
      run(r1, l1, b1, d1, r2, l2, b2, d2);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
